// File: rtl/bcd_serial_adder_if.sv
// Handshake and operand/result bundle for the digit-serial BCD adder.
// The master side supplies operands and consumes results; the slave side is the adder.
interface bcd_serial_adder_if #(
   parameter int DIGITS = 4
);
   logic                  in_valid;
   logic                  in_ready;
   logic [4*DIGITS-1:0]   A;
   logic [4*DIGITS-1:0]   B;
   logic                  Cin;
   logic [4*DIGITS-1:0]   Sum;
   logic                  Co;
   logic                  err;
   logic                  out_valid;
   logic                  out_ready;
   logic                  busy;

   modport master (
      output in_valid, A, B, Cin, out_ready,
      input  in_ready, Sum, Co, err, out_valid, busy
   );

   modport slave (
      input  in_valid, A, B, Cin, out_ready,
      output in_ready, Sum, Co, err, out_valid, busy
   );
endinterface

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: accepts an operand set, adds one digit per cycle
// LSD first, then holds the result until the downstream side consumes it.
module bcd_serial_adder #(
   parameter int DIGITS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   bcd_serial_adder_if.slave    bus
);

   localparam int W     = 4 * DIGITS;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            nextState;

   logic [W-1:0]      aReg;
   logic [W-1:0]      bReg;
   logic [W-1:0]      sumReg;
   logic              carry;
   logic [IDX_W-1:0]  index;
   logic              coReg;
   logic              errReg;

   logic              accept;
   logic              lastDigit;
   logic              inDigitsBad;
   logic [3:0]        aDigit;
   logic [3:0]        bDigit;
   logic [4:0]        temp;
   logic [3:0]        digitSum;
   logic              digitCarry;

   assign accept    = (state == IDLE) && bus.in_valid;
   assign lastDigit = (index == LAST_IDX);

   // Any nibble above 9 in either operand marks the whole operation as suspect.
   always_comb begin
      inDigitsBad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if ((bus.A[4*i +: 4] > 4'd9) || (bus.B[4*i +: 4] > 4'd9)) begin
            inDigitsBad = 1'b1;
         end
      end
   end

   // One BCD digit add; invalid nibbles go through the same correction unchanged.
   always_comb begin
      aDigit     = aReg[4*index +: 4];
      bDigit     = bReg[4*index +: 4];
      temp       = {1'b0, aDigit} + {1'b0, bDigit} + {4'b0000, carry};
      digitSum   = temp[3:0];
      digitCarry = 1'b0;
      if (temp > 5'd9) begin
         digitSum   = 4'(temp - 5'd10);
         digitCarry = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state and handshake outputs; out_ready only matters in DONE.
   always_comb begin
      nextState     = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b1;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            bus.busy     = 1'b0;
            if (bus.in_valid) begin
               nextState = ADD;
            end
         end
         ADD: begin
            if (lastDigit) begin
               nextState = DONE;
            end
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               nextState = IDLE;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Operand capture and the per-digit ripple; results persist until the next accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         aReg   <= '0;
         bReg   <= '0;
         sumReg <= '0;
         carry  <= 1'b0;
         index  <= '0;
         coReg  <= 1'b0;
         errReg <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  aReg   <= bus.A;
                  bReg   <= bus.B;
                  carry  <= bus.Cin;
                  index  <= '0;
                  sumReg <= '0;
                  errReg <= inDigitsBad;
               end
            end
            ADD: begin
               sumReg[4*index +: 4] <= digitSum;
               carry                <= digitCarry;
               if (lastDigit) begin
                  coReg <= digitCarry;
               end else begin
                  index <= index + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.Sum = sumReg;
   assign bus.Co  = coReg;
   assign bus.err = errReg;

endmodule
